loss_unit: RTL and testbench

//  Multi-mode, lane-parallel loss evaluator; successor of the single-shot L1/L2 loss block.

---
 rtl/loss_unit_if.sv | 28 ++
 rtl/loss_unit.sv | 200 ++++++++++++++++++++
 tb/tb_loss_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/loss_unit_if.sv
// Producer/consumer bundle for loss_unit: captured vectors, control and the ready/taken handshake.
interface loss_unit_if #(
  parameter int unsigned IL    = 8,
  parameter int unsigned FL    = 12,
  parameter int unsigned size  = 16,
  parameter int unsigned width = $clog2(size) + 1
);
  localparam int unsigned DW = IL + FL;

  logic [1:0]                mode;
  logic [width-1:0]          num;
  logic [size-1:0][DW-1:0]   yHat;
  logic [size-1:0][DW-1:0]   y;
  logic                      input_ready;
  logic                      output_taken;
  logic [1:0]                state;
  logic [DW-1:0]             out;

  modport master (
    output mode, num, yHat, y, input_ready, output_taken,
    input  state, out
  );

  modport slave (
    input  mode, num, yHat, y, input_ready, output_taken,
    output state, out
  );
endinterface

// File: rtl/loss_unit.sv
// Lane-parallel L1/L2/Linf loss evaluator with saturated Q(IL.FL) result.
// Define LOSS_UNIT_MEAN_EN to divide the accumulated loss by the element count (Linf excluded).
module loss_unit #(
  parameter int unsigned IL    = 8,
  parameter int unsigned FL    = 12,
  parameter int unsigned size  = 16,
  parameter int unsigned width = $clog2(size) + 1,
  parameter int unsigned LANES = 4
) (
  input logic        clk,
  input logic        reset,
  loss_unit_if.slave bus
);

  localparam int unsigned DW    = IL + FL;
  localparam int unsigned ACC_W = 2 * DW + width;
  localparam int unsigned IdxW  = $clog2(size);
  localparam logic [ACC_W-1:0] SatMax = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDiv  = 2'b11,
    StDone = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [size-1:0][DW-1:0] yhat_q, yhat_d, y_q, y_d;
  logic [1:0]              mode_q, mode_d;
  logic [width-1:0]        num_eff_q, num_eff_d, idx_q, idx_d;
  logic [ACC_W-1:0]        acc_q, acc_d, acc_next;
  logic [DW-1:0]           out_q, out_d;

  logic [width-1:0]        e;
  logic [IdxW-1:0]         e_sel;
  logic signed [DW:0]      diff;
  logic [DW:0]             mag;
  logic [2*DW+1:0]         sq;
  logic                    last_chunk;

  function automatic logic [DW-1:0] saturate(input logic [ACC_W-1:0] v);
    return (v > SatMax) ? SatMax[DW-1:0] : v[DW-1:0];
  endfunction

  // One BUSY cycle worth of lanes folded into the accumulator.
  always_comb begin
    acc_next = acc_q;
    e        = '0;
    e_sel    = '0;
    diff     = '0;
    mag      = '0;
    sq       = '0;
    for (int k = 0; k < LANES; k++) begin
      e     = idx_q + width'(k);
      e_sel = e[IdxW-1:0];
      if (e < num_eff_q) begin
        diff = $signed({yhat_q[e_sel][DW-1], yhat_q[e_sel]})
             - $signed({y_q[e_sel][DW-1], y_q[e_sel]});
        mag  = diff[DW] ? -diff : diff;
        sq   = diff * diff;
        case (mode_q)
          2'b01:   acc_next = acc_next + ACC_W'(mag);
          2'b10:   if (ACC_W'(mag) > acc_next) acc_next = ACC_W'(mag);
          default: acc_next = acc_next + ACC_W'(sq >> FL);
        endcase
      end
    end
  end

  assign last_chunk = ({1'b0, idx_q} + (width+1)'(LANES)) >= {1'b0, num_eff_q};

`ifdef LOSS_UNIT_MEAN_EN
  localparam int unsigned CntW = $clog2(ACC_W + 1);

  logic [width-1:0] rem_q, rem_d, rem_step;
  logic [ACC_W-1:0] quot_q, quot_d, quot_step;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [width:0]   rem_sh;
  logic             rem_ge;

  // Restoring divider: dividend shifts out of quot_q as quotient bits shift in.
  always_comb begin
    rem_sh    = {rem_q, quot_q[ACC_W-1]};
    rem_ge    = rem_sh >= {1'b0, num_eff_q};
    rem_step  = rem_ge ? width'(rem_sh - {1'b0, num_eff_q}) : rem_sh[width-1:0];
    quot_step = {quot_q[ACC_W-2:0], rem_ge};
  end
`endif

  always_comb begin
    state_d   = state_q;
    yhat_d    = yhat_q;
    y_d       = y_q;
    mode_d    = mode_q;
    num_eff_d = num_eff_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    out_d     = out_q;
`ifdef LOSS_UNIT_MEAN_EN
    rem_d     = rem_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.input_ready) begin
          yhat_d    = bus.yHat;
          y_d       = bus.y;
          mode_d    = bus.mode;
          num_eff_d = (bus.num > width'(size)) ? width'(size) : bus.num;
          idx_d     = '0;
          acc_d     = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        acc_d = acc_next;
        idx_d = idx_q + width'(LANES);
        if (last_chunk) begin
`ifdef LOSS_UNIT_MEAN_EN
          if (mode_q != 2'b10) begin
            state_d = StDiv;
            quot_d  = acc_next;
            rem_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = StDone;
            out_d   = saturate(acc_next);
          end
`else
          state_d = StDone;
          out_d   = saturate(acc_next);
`endif
        end
      end
      StDiv: begin
`ifdef LOSS_UNIT_MEAN_EN
        rem_d  = rem_step;
        quot_d = quot_step;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ACC_W - 1)) begin
          state_d = StDone;
          out_d   = (num_eff_q == '0) ? '0 : saturate(quot_step);
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        if (bus.output_taken) begin
          state_d   = StIdle;
          out_d     = '0;
          yhat_d    = '0;
          y_d       = '0;
          mode_d    = '0;
          num_eff_d = '0;
          idx_d     = '0;
          acc_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      yhat_q    <= '0;
      y_q       <= '0;
      mode_q    <= '0;
      num_eff_q <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      out_q     <= '0;
`ifdef LOSS_UNIT_MEAN_EN
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      yhat_q    <= yhat_d;
      y_q       <= y_d;
      mode_q    <= mode_d;
      num_eff_q <= num_eff_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
`ifdef LOSS_UNIT_MEAN_EN
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.state = state_q;
  assign bus.out   = out_q;

endmodule

// File: tb/tb_loss_unit.sv
// Directed scoreboard bench for loss_unit; expectations follow LOSS_UNIT_MEAN_EN when defined.
module tb_loss_unit;
  localparam int DW = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  loss_unit_if bus ();
  loss_unit dut (.clk(clk), .reset(reset), .bus(bus));

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;
  logic [31:0] sb[$];

`ifdef LOSS_UNIT_MEAN_EN
  localparam bit Mean = 1'b1;
`else
  localparam bit Mean = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_vec();
    for (int i = 0; i < 16; i++) begin
      bus.yHat[i] = '0;
      bus.y[i]    = '0;
    end
  endtask

  task automatic set_el(input int i, input int yh, input int yv);
    bus.yHat[i] = DW'(yh);
    bus.y[i]    = DW'(yv);
  endtask

  // Called on a negedge while IDLE; returns on the negedge of the first BUSY cycle.
  task automatic start(input logic [1:0] m, input logic [4:0] n, input logic [31:0] exp);
    bus.mode        = m;
    bus.num         = n;
    bus.input_ready = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    bus.input_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int busy);
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.state == 2'b10) break;
      if (bus.state == 2'b01) busy++;
      @(negedge clk);
    end
    check({tag, " reached DONE"}, 32'(bus.state), 32'd2);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] exp;
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    check({tag, " out"}, 32'(bus.out), exp);
  endtask

  task automatic finish_txn(input string tag, input int exp_busy, input int hold);
    int busy;
    logic [31:0] exp;
    wait_done(tag, busy);
    check({tag, " busy cycles"}, 32'(busy), 32'(exp_busy));
    exp = (sb.size() != 0) ? sb[0] : 'x;
    for (int i = 0; i < hold; i++) begin
      check({tag, " out held"}, 32'(bus.out), exp);
      @(negedge clk);
    end
    pop_check(tag);
    bus.output_taken = 1'b1;
    @(negedge clk);
    bus.output_taken = 1'b0;
    check({tag, " idle after taken"}, 32'(bus.state), 32'd0);
    check({tag, " out cleared"}, 32'(bus.out), 32'd0);
  endtask

  initial begin
    reset            = 1'b1;
    bus.mode         = '0;
    bus.num          = '0;
    bus.input_ready  = 1'b0;
    bus.output_taken = 1'b0;
    clear_vec();
    repeat (2) @(negedge clk);
    check("reset state", 32'(bus.state), 32'd0);
    check("reset out", 32'(bus.out), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // L1, sum 5.0 over 4 elements; out must hold while not taken
    clear_vec();
    set_el(0, 4096, 0); set_el(1, 8192, 0); set_el(2, 0, 4096); set_el(3, 0, -4096);
    start(2'b01, 5'd4, Mean ? 32'd5120 : 32'd20480);
    finish_txn("t1 L1", 1, 5);

    // L2, diffs 2.0 and 3.0; mode 11 must behave as L2
    clear_vec();
    set_el(0, 8192, 0); set_el(1, 0, -12288);
    start(2'b00, 5'd2, Mean ? 32'd26624 : 32'd53248);
    finish_txn("t2 L2", 1, 0);
    start(2'b11, 5'd2, Mean ? 32'd26624 : 32'd53248);
    finish_txn("t2b mode11", 1, 0);

    // L2 saturation with full vector
    clear_vec();
    for (int i = 0; i < 16; i++) set_el(i, 204800, -204800);
    start(2'b00, 5'd16, 32'd524287);
    finish_txn("t3 L2 sat", 4, 0);

    // Linf; mode input changed after capture must be ignored
    clear_vec();
    set_el(0, 0, 14336); set_el(1, 4096, 0); set_el(2, 0, -8192);
    start(2'b10, 5'd3, 32'd14336);
    bus.mode = 2'b01;
    finish_txn("t4 Linf", 1, 0);

    // Empty vector
    start(2'b01, 5'd0, 32'd0);
    finish_txn("t4b num0", 1, 0);

    // num above size clamps to 16
    clear_vec();
    for (int i = 0; i < 16; i++) set_el(i, 2048, 0);
    start(2'b01, 5'd20, Mean ? 32'd2048 : 32'd32768);
    finish_txn("t5 clamp", 4, 0);

    // Reset during the second BUSY cycle aborts
    bus.mode        = 2'b00;
    bus.num         = 5'd16;
    bus.input_ready = 1'b1;
    @(negedge clk);
    bus.input_ready = 1'b0;
    check("t6 first busy", 32'(bus.state), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6 reset state", 32'(bus.state), 32'd0);
    check("t6 reset out", 32'(bus.out), 32'd0);
    @(negedge clk);
    check("t6 stays idle", 32'(bus.state), 32'd0);

    // output_taken with simultaneous input_ready: back to IDLE, no capture
    clear_vec();
    set_el(0, 4096, 0); set_el(1, 8192, 0); set_el(2, 0, 4096); set_el(3, 0, -4096);
    start(2'b01, 5'd4, Mean ? 32'd5120 : 32'd20480);
    begin
      int busy;
      wait_done("t7", busy);
    end
    pop_check("t7");
    bus.output_taken = 1'b1;
    bus.input_ready  = 1'b1;
    @(negedge clk);
    bus.output_taken = 1'b0;
    bus.input_ready  = 1'b0;
    check("t7 idle", 32'(bus.state), 32'd0);
    check("t7 out cleared", 32'(bus.out), 32'd0);
    @(negedge clk);
    check("t7 no capture", 32'(bus.state), 32'd0);
    check("t7 scoreboard empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
